// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - in-order write-back queue feeding the register file write port.
// Optional youngest-value forwarding lookups are built when WB_FORWARD_EN is defined.
module wb_write_queue #(
    parameter int REGWIDTH = 16,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [2:0]               enq_sel,
    input  logic [REGWIDTH-1:0]      enq_data,
    output logic                     enq_ready,
    input  logic                     hold,
    output logic                     wr_en,
    output logic [2:0]               wr_sel,
    output logic [REGWIDTH-1:0]      wr_data,
    input  logic [2:0]               lk1_sel,
    input  logic [2:0]               lk2_sel,
    output logic                     lk1_hit,
    output logic                     lk2_hit,
    output logic [REGWIDTH-1:0]      lk1_data,
    output logic [REGWIDTH-1:0]      lk2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [PTRW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic                err_q, err_d;
    logic [2:0]          sel_mem_q [DEPTH];
    logic [2:0]          sel_mem_d [DEPTH];
    logic [REGWIDTH-1:0] data_mem_q [DEPTH];
    logic [REGWIDTH-1:0] data_mem_d [DEPTH];
    logic [2:0]          wr_sel_q, wr_sel_d;
    logic [REGWIDTH-1:0] wr_data_q, wr_data_d;
    logic                enq_fire;

    assign enq_ready = (count_q != CNTW'(DEPTH));
    assign wr_en     = (count_q != '0) && !hold;
    assign wr_sel    = wr_sel_q;
    assign wr_data   = wr_data_q;
    assign count     = count_q;
    assign err       = err_q;
    assign enq_fire  = enq_valid && enq_ready;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        sel_mem_d  = sel_mem_q;
        data_mem_d = data_mem_q;
        err_d      = err_q | (enq_valid & ~enq_ready);
        if (enq_fire) begin
            sel_mem_d[tail_q]  = enq_sel;
            data_mem_d[tail_q] = enq_data;
            tail_d             = tail_q + PTRW'(1);
        end
        if (wr_en) begin
            head_d = head_q + PTRW'(1);
        end
        if (enq_fire && !wr_en) begin
            count_d = count_q + CNTW'(1);
        end else if (!enq_fire && wr_en) begin
            count_d = count_q - CNTW'(1);
        end
        // Output registers preload the next head slot, including a slot written this edge.
        wr_sel_d  = sel_mem_d[head_d];
        wr_data_d = data_mem_d[head_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_q     <= err_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        sel_mem_q  <= sel_mem_d;
        data_mem_q <= data_mem_d;
    end

`ifdef WB_FORWARD_EN
    logic [PTRW-1:0] lk_idx;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        lk_idx   = '0;
        lk1_hit  = 1'b0;
        lk2_hit  = 1'b0;
        lk1_data = '0;
        lk2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PTRW'(i);
            if (CNTW'(i) < count_q) begin
                if (sel_mem_q[lk_idx] == lk1_sel) begin
                    lk1_hit  = 1'b1;
                    lk1_data = data_mem_q[lk_idx];
                end
                if (sel_mem_q[lk_idx] == lk2_sel) begin
                    lk2_hit  = 1'b1;
                    lk2_data = data_mem_q[lk_idx];
                end
            end
        end
    end
`else
    logic unused_lk;
    assign unused_lk = ^{lk1_sel, lk2_sel};
    assign lk1_hit   = 1'b0;
    assign lk2_hit   = 1'b0;
    assign lk1_data  = '0;
    assign lk2_data  = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - randomized and directed bench for wb_write_queue against a queue model.
module tb_wb_write_queue;

    localparam int REGWIDTH = 16;
    localparam int DEPTH    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enq_valid = 1'b0;
    logic [2:0]          enq_sel = '0;
    logic [REGWIDTH-1:0] enq_data = '0;
    logic                enq_ready;
    logic                hold = 1'b0;
    logic                wr_en;
    logic [2:0]          wr_sel;
    logic [REGWIDTH-1:0] wr_data;
    logic [2:0]          lk1_sel = '0;
    logic [2:0]          lk2_sel = '0;
    logic                lk1_hit, lk2_hit;
    logic [REGWIDTH-1:0] lk1_data, lk2_data;
    logic [$clog2(DEPTH):0] count;
    logic                err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]          sel;
        logic [REGWIDTH-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   m_err = 1'b0;

    wb_write_queue #(.REGWIDTH(REGWIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_sel(enq_sel), .enq_data(enq_data), .enq_ready(enq_ready),
        .hold(hold), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .lk1_sel(lk1_sel), .lk2_sel(lk2_sel), .lk1_hit(lk1_hit), .lk2_hit(lk2_hit),
        .lk1_data(lk1_data), .lk2_data(lk2_data), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void exp_lookup(input logic [2:0] s, output bit h, output logic [REGWIDTH-1:0] d);
        h = 1'b0;
        d = '0;
        foreach (q[i]) begin
            if (q[i].sel == s) begin
                h = 1'b1;
                d = q[i].data;
            end
        end
`ifndef WB_FORWARD_EN
        h = 1'b0;
        d = '0;
`endif
    endfunction

    task automatic cycle(input bit v, input logic [2:0] s, input logic [REGWIDTH-1:0] d, input bit h);
        bit full, do_enq, do_deq, eh;
        logic [REGWIDTH-1:0] ed;
        enq_valid = v;
        enq_sel   = s;
        enq_data  = d;
        hold      = h;
        @(negedge clk);
        full = (q.size() == DEPTH);
        do_enq = v && !full;
        do_deq = (q.size() != 0) && !h;
        check("enq_ready", 32'(enq_ready), 32'(!full));
        check("wr_en", 32'(wr_en), 32'(do_deq));
        if (do_deq) begin
            check("wr_sel", 32'(wr_sel), 32'(q[0].sel));
            check("wr_data", 32'(wr_data), 32'(q[0].data));
        end
        check("count", 32'(count), 32'(q.size()));
        check("err", 32'(err), 32'(m_err));
        exp_lookup(lk1_sel, eh, ed);
        check("lk1_hit", 32'(lk1_hit), 32'(eh));
        check("lk1_data", 32'(lk1_data), 32'(ed));
        exp_lookup(lk2_sel, eh, ed);
        check("lk2_hit", 32'(lk2_hit), 32'(eh));
        check("lk2_data", 32'(lk2_data), 32'(ed));
        if (v && full) m_err = 1'b1;
        @(posedge clk);
        #1;
        if (do_deq) void'(q.pop_front());
        if (do_enq) q.push_back('{sel: s, data: d});
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enq_valid = 1'b0;
        hold      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_err = 1'b0;
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_wr_sel", 32'(wr_sel), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_lk1_hit", 32'(lk1_hit), 32'd0);
        check("rst_lk2_hit", 32'(lk2_hit), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // Single request: accepted, presented next cycle, drained.
        cycle(1'b1, 3'd3, 16'hBEEF, 1'b0);
        check("beef_wr_en", 32'(wr_en), 32'd1);
        check("beef_wr_sel", 32'(wr_sel), 32'd3);
        check("beef_wr_data", 32'(wr_data), 32'hBEEF);
        cycle(1'b0, 3'd0, 16'h0, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 1'b0);

        // Fill under hold, then release and drain in order.
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 16'h0010 + 16'(i), 1'b1);
        cycle(1'b0, 3'd0, 16'h0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 16'h0, 1'b0);

        // Overflow: dropped request, sticky err.
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i + 4), 16'h0A00 + 16'(i), 1'b1);
        cycle(1'b1, 3'd7, 16'hDEAD, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'(i % 2), 3'(i), 16'h0B00 + 16'(i), 1'b0);
        do_reset();

        // Steady state across pointer wrap.
        for (int i = 0; i < 20; i++) cycle(1'b1, 3'(i), 16'(i * 16'h0101 + 1), 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 1'b0);

        // Forwarding of the youngest pending value.
        do_reset();
        cycle(1'b1, 3'd5, 16'h1111, 1'b1);
        cycle(1'b1, 3'd5, 16'h2222, 1'b1);
        lk1_sel = 3'd5;
        lk2_sel = 3'd6;
        cycle(1'b0, 3'd0, 16'h0, 1'b1);
`ifdef WB_FORWARD_EN
        check("fwd_lk1_data", 32'(lk1_data), 32'h2222);
`endif

        // Reset with entries pending.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'(i), 16'h0C00 + 16'(i), 1'b1);
        check("pre_rst_count", 32'(count), 32'd3);
        do_reset();

        // Randomized traffic, occasional protocol violations near the end.
        for (int n = 0; n < 400; n++) begin
            bit v, h;
            v = ($urandom % 3) != 0;
            h = ($urandom % 4) == 0;
            if (q.size() == DEPTH && n < 380) v = 1'b0;
            lk1_sel = 3'($urandom);
            lk2_sel = 3'($urandom);
            cycle(v, 3'($urandom), 16'($urandom), h);
        end
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
